// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared up/up-down period counter, per-channel
// double-buffered duty compare with output polarity, edge- or center-aligned.
module pwm_multi_channel #(
  parameter int CH = 4,
  parameter int WIDTH = 8,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             center,
  input  logic [WIDTH-1:0] period,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CH-1:0]    pol,
  output logic [CH-1:0]    pwm_out,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] per_act_q, per_act_d;
  logic             mode_act_q, mode_act_d;
  logic [CH-1:0]    pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;

  logic             boundary;
  logic [WIDTH-1:0] per_eff;
  logic             mode_eff;
  logic             center_run;
  logic [CH-1:0]    raw;

  // The boundary cycle already runs with the freshly loaded shadows, so the
  // new period/mode/duty govern the whole period starting at cnt=0.
  assign boundary   = en && (cnt_q == '0) && (dir_q == DIR_UP);
  assign per_eff    = boundary ? period : per_act_q;
  assign mode_eff   = boundary ? center : mode_act_q;
  assign center_run = mode_eff && (per_eff != '0);

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (!center_run) begin
      dir_d = DIR_UP;
      cnt_d = (cnt_q >= per_eff) ? '0 : cnt_q + ONE;
    end else begin
      case (dir_q)
        DIR_UP: begin
          if (cnt_q >= per_eff) begin
            cnt_d = cnt_q - ONE;
            dir_d = (cnt_q <= ONE) ? DIR_UP : DIR_DOWN;
          end else begin
            cnt_d = cnt_q + ONE;
            dir_d = DIR_UP;
          end
        end
        DIR_DOWN: begin
          if (cnt_q <= ONE) begin
            cnt_d = '0;
            dir_d = DIR_UP;
          end else begin
            cnt_d = cnt_q - ONE;
            dir_d = DIR_DOWN;
          end
        end
        default: begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end
      endcase
    end
  end

  always_comb begin
    per_act_d      = per_eff;
    mode_act_d     = mode_eff;
    pwm_out_d      = en ? (raw ^ pol) : '0;
    period_start_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      per_act_q      <= '0;
      mode_act_q     <= 1'b0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      per_act_q      <= per_act_d;
      mode_act_q     <= mode_act_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  // Channel indices >= CH never match any slice, so such writes fall away.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
      logic [WIDTH-1:0] duty_act_q, duty_act_d;
      logic [WIDTH-1:0] duty_eff;
      logic             wr_hit;

      assign wr_hit   = wr_en && (wr_ch == CW'(gi));
      assign duty_eff = boundary ? duty_pend_q : duty_act_q;
      assign raw[gi]  = (cnt_q < duty_eff);

      always_comb begin
        duty_pend_d = wr_hit ? wr_data : duty_pend_q;
        duty_act_d  = duty_eff;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          duty_pend_q <= '0;
          duty_act_q  <= '0;
        end else begin
          duty_pend_q <= duty_pend_d;
          duty_act_q  <= duty_act_d;
        end
      end
    end
  endgenerate

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: directed scenarios plus a random
// run, all compared against a phase-based behavioural model of the PWM rules.
module tb_pwm_multi_channel;

  localparam int CH = 4;
  localparam int WIDTH = 8;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             center;
  logic [WIDTH-1:0] period;
  logic             wr_en;
  logic [CW-1:0]    wr_ch;
  logic [WIDTH-1:0] wr_data;
  logic [CH-1:0]    pol;
  logic [CH-1:0]    pwm_out;
  logic             period_start;

  int errors = 0;
  int checks = 0;

  // Model: position within the current period plus the loaded shadow values.
  int            m_pend[CH];
  int            m_act[CH];
  int            m_per, m_mode, m_t;
  logic [CH-1:0] exp_pwm;
  logic          exp_ps;

  always #5 clk = ~clk;

  pwm_multi_channel #(.CH(CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .center(center), .period(period),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .pol(pol),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  function automatic int m_len();
    return (m_mode != 0 && m_per >= 1) ? 2 * m_per : m_per + 1;
  endfunction

  // Counter value at a phase: rising ramp, folded back down in center mode.
  function automatic int m_cnt();
    return (m_mode != 0 && m_per >= 1 && m_t > m_per) ? 2 * m_per - m_t : m_t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0;
      m_act[i]  = 0;
    end
    m_per = 0; m_mode = 0; m_t = 0;
    exp_pwm = '0; exp_ps = 1'b0;
  endtask

  // Predict the registered outputs for the current inputs, then clock once.
  task automatic tick();
    if (!en) begin
      exp_pwm = '0;
      exp_ps  = 1'b0;
      m_t     = 0;
    end else begin
      exp_ps = (m_t == 0);
      if (m_t == 0) begin
        for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
        m_per  = int'(period);
        m_mode = int'(center);
      end
      for (int i = 0; i < CH; i++)
        exp_pwm[i] = ((m_cnt() < m_act[i]) ? 1'b1 : 1'b0) ^ pol[i];
      m_t = (m_t + 1) % m_len();
    end
    if (wr_en && int'(wr_ch) < CH) m_pend[wr_ch] = int'(wr_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; center = 1'b0; period = '0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0; pol = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: pwm_out=%b period_start=%b expected 0000 0", pwm_out, period_start);
    end
    rst = 1'b0;
    pol = 4'b1111;
    tick();
    checks++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_disabled: pwm_out=%b period_start=%b expected 0000 0", pwm_out, period_start);
    end
    pol = '0;
    $display("test_reset done");
  endtask

  task automatic test_edge();
    int highs, starts;
    highs = 0; starts = 0;
    en = 1'b1; period = 8'd9; center = 1'b0;
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'd3;
    for (int n = 0; n < 40; n++) begin
      tick();
      wr_en = 1'b0;
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL edge_cycle%0d: pwm_out=%b period_start=%b expected %b %b", n, pwm_out, period_start, exp_pwm, exp_ps);
      end
      if (n >= 10 && n < 30) begin
        highs  += int'(pwm_out[0]);
        starts += int'(period_start);
      end
    end
    checks++;
    if (highs !== 6 || starts !== 2) begin
      errors++;
      $display("FAIL edge_duty3: ch0 highs=%0d starts=%0d expected 6 2", highs, starts);
    end
    $display("test_edge done: ch0 high %0d of 20 cycles", highs);
  endtask

  task automatic test_center();
    int highs, starts;
    highs = 0; starts = 0;
    center = 1'b1; period = 8'd4;
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'd2;
    for (int n = 0; n < 40; n++) begin
      tick();
      wr_en = 1'b0;
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL center_cycle%0d: pwm_out=%b period_start=%b expected %b %b", n, pwm_out, period_start, exp_pwm, exp_ps);
      end
      if (n >= 24) begin
        highs  += int'(pwm_out[1]);
        starts += int'(period_start);
      end
    end
    checks++;
    if (highs !== 6 || starts !== 2) begin
      errors++;
      $display("FAIL center_duty2: ch1 highs=%0d starts=%0d expected 6 2", highs, starts);
    end
    $display("test_center done: ch1 high %0d of 16 cycles", highs);
  endtask

  task automatic test_extremes();
    int seen23;
    seen23 = 0;
    center = 1'b0; period = 8'd9; pol = 4'b1000;
    wr_en = 1'b1; wr_ch = 2'd2; wr_data = 8'd0;
    tick();
    wr_ch = 2'd3; wr_data = 8'd255;
    for (int n = 0; n < 40; n++) begin
      tick();
      wr_en = 1'b0;
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL extreme_cycle%0d: pwm_out=%b period_start=%b expected %b %b", n, pwm_out, period_start, exp_pwm, exp_ps);
      end
      if (n >= 20) seen23 += int'(pwm_out[2]) + int'(pwm_out[3]);
    end
    checks++;
    if (seen23 !== 0) begin
      errors++;
      $display("FAIL extreme_const: ch2/ch3 high count=%0d expected 0", seen23);
    end
    $display("test_extremes done");
  endtask

  task automatic test_boundary_write();
    int h1, h2, guard;
    h1 = 0; h2 = 0; guard = 0;
    pol = '0;
    while (m_t != 0 && guard < 30) begin
      tick();
      guard++;
    end
    checks++;
    if (m_t != 0) begin
      errors++;
      $display("FAIL bw_align: phase=%0d expected 0", m_t);
    end
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'd7;
    for (int n = 0; n < 20; n++) begin
      tick();
      wr_en = 1'b0;
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL bw_cycle%0d: pwm_out=%b period_start=%b expected %b %b", n, pwm_out, period_start, exp_pwm, exp_ps);
      end
      if (n < 10) h1 += int'(pwm_out[0]);
      else        h2 += int'(pwm_out[0]);
    end
    checks++;
    if (h1 !== 3 || h2 !== 7) begin
      errors++;
      $display("FAIL bw_commit: ch0 highs=%0d,%0d expected 3,7", h1, h2);
    end
    $display("test_boundary_write done: periods %0d then %0d", h1, h2);
  endtask

  task automatic test_async_reset();
    int guard, seen;
    guard = 0; seen = 0;
    while (m_t != 5 && guard < 30) begin
      tick();
      guard++;
    end
    checks++;
    if (m_t != 5 || pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL ar_align: phase=%0d ch0=%b expected 5 1", m_t, pwm_out[0]);
    end
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'd9;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (pwm_out !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: pwm_out=%b period_start=%b expected 0000 0", pwm_out, period_start);
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 12; n++) begin
      tick();
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL ar_cycle%0d: pwm_out=%b period_start=%b expected %b %b", n, pwm_out, period_start, exp_pwm, exp_ps);
      end
      seen += int'(|pwm_out);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL ar_duty_cleared: cycles with output high=%0d expected 0", seen);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_disable();
    en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      wr_en = 1'b1;
      wr_ch = CW'($urandom_range(0, CH - 1));
      wr_data = WIDTH'($urandom_range(1, 9));
      pol = CH'($urandom);
      tick();
      checks++;
      if (pwm_out !== '0 || period_start !== 1'b0) begin
        errors++;
        $display("FAIL dis_cycle%0d: pwm_out=%b period_start=%b expected 0000 0", n, pwm_out, period_start);
      end
    end
    wr_en = 1'b0; en = 1'b1; period = 8'd9; center = 1'b0;
    for (int n = 0; n < 25; n++) begin
      tick();
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL en_cycle%0d: pwm_out=%b period_start=%b expected %b %b", n, pwm_out, period_start, exp_pwm, exp_ps);
      end
      if (n == 0) begin
        checks++;
        if (period_start !== 1'b1) begin
          errors++;
          $display("FAIL en_first_boundary: period_start=%b expected 1", period_start);
        end
      end
    end
    $display("test_disable done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        period = WIDTH'($urandom_range(0, 12));
        center = 1'($urandom_range(0, 1));
        pol    = CH'($urandom);
      end
      en      = ($urandom_range(0, 29) != 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_ch   = CW'($urandom_range(0, CH - 1));
      wr_data = ($urandom_range(0, 9) == 0) ? 8'd255 : WIDTH'($urandom_range(0, 14));
      tick();
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        errors++;
        $display("FAIL rand_cycle%0d: pwm_out=%b period_start=%b expected %b %b", n, pwm_out, period_start, exp_pwm, exp_ps);
      end
    end
    wr_en = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_extremes();
    test_boundary_write();
    test_async_reset();
    test_disable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
